travel_ctrl: RTL

TRAVEL_CTRL -- requirements
Module: travel_ctrl

---
 rtl/travel_ctrl_pkg.sv | 17 +
 rtl/travel_ctrl_if.sv | 34 +++
 rtl/frame_tick.sv | 18 +
 rtl/travel_ctrl.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/travel_ctrl_pkg.sv
// Shared definitions for the cursor travel controller and its position mover:
// mode encoding, coordinate widths and default display extent.
package travel_ctrl_pkg;

  localparam int X_W         = 11;
  localparam int Y_W         = 10;
  localparam int H_LIMIT_DEF = 800;
  localparam int V_LIMIT_DEF = 600;

  typedef enum logic [1:0] {
    MODE_IDLE   = 2'd0,
    MODE_MANUAL = 2'd1,
    MODE_AUTO   = 2'd2,
    MODE_HOLD   = 2'd3
  } mode_t;

endpackage

// File: rtl/travel_ctrl_if.sv
// Request/command bundle between a travel requester (master) and travel_ctrl (slave).
interface travel_ctrl_if;
  import travel_ctrl_pkg::*;

  logic           btn_up;
  logic           btn_down;
  logic           btn_left;
  logic           btn_right;
  logic           go;
  logic [X_W-1:0] tgt_x;
  logic [Y_W-1:0] tgt_y;
  logic [X_W-1:0] cur_x;
  logic [Y_W-1:0] cur_y;
  logic           move_en;
  logic           up;
  logic           down;
  logic           left;
  logic           right;
  logic [1:0]     mode;
  logic           busy;
  logic           arrived;
  logic           aborted;

  modport master (
    output btn_up, btn_down, btn_left, btn_right, go, tgt_x, tgt_y, cur_x, cur_y,
    input  move_en, up, down, left, right, mode, busy, arrived, aborted
  );

  modport slave (
    input  btn_up, btn_down, btn_left, btn_right, go, tgt_x, tgt_y, cur_x, cur_y,
    output move_en, up, down, left, right, mode, busy, arrived, aborted
  );

endinterface

// File: rtl/frame_tick.sv
// vsync falling-edge detector: one-cycle tick per high-to-low transition.
module frame_tick (
  input  logic clk,
  input  logic rst_n,
  input  logic vsync,
  output logic tick
);

  logic vsync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vsync_q <= 1'b0;
    else        vsync_q <= vsync;
  end

  assign tick = vsync_q & ~vsync;

endmodule

// File: rtl/travel_ctrl.sv
// Frame-paced cursor travel controller: manual buttons, hold-off, and auto travel to a target.
// Define MOVE_DIAGONAL_EN to let auto travel step both axes in the same frame.
module travel_ctrl
  import travel_ctrl_pkg::*;
#(
  parameter int HOLD_FRAMES = 60,
  parameter int H_LIMIT     = H_LIMIT_DEF,
  parameter int V_LIMIT     = V_LIMIT_DEF
) (
  input logic          clk,
  input logic          rst_n,
  input logic          vsync,
  travel_ctrl_if.slave bus
);

  localparam int                CNT_W     = $clog2(HOLD_FRAMES + 2);
  localparam logic [CNT_W-1:0]  HOLD_LOAD = CNT_W'(HOLD_FRAMES);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [X_W-1:0]    X_MAX     = X_W'(H_LIMIT - 1);
  localparam logic [Y_W-1:0]    Y_MAX     = Y_W'(V_LIMIT - 1);

  function automatic logic [X_W-1:0] sat_x(input logic [X_W-1:0] v);
    return (v > X_MAX) ? X_MAX : v;
  endfunction

  function automatic logic [Y_W-1:0] sat_y(input logic [Y_W-1:0] v);
    return (v > Y_MAX) ? Y_MAX : v;
  endfunction

  mode_t            state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             go_pend_q, go_pend_d;
  logic [X_W-1:0]   tx_q, tx_d;
  logic [Y_W-1:0]   ty_q, ty_d;
  logic             move_en_q, move_en_d;
  logic             arrived_q, arrived_d;
  logic             aborted_q, aborted_d;
  logic [3:0]       dir_q, dir_d, man_dir, auto_dir;  // {up, down, left, right}
  logic             tick, manual, at_tgt, auto_eval, y_ok;

  frame_tick u_frame_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .vsync (vsync),
    .tick  (tick)
  );

  assign manual  = bus.btn_up | bus.btn_down | bus.btn_left | bus.btn_right;
  assign man_dir = {bus.btn_up   & ~bus.btn_down, bus.btn_down  & ~bus.btn_up,
                    bus.btn_left & ~bus.btn_right, bus.btn_right & ~bus.btn_left};
  assign at_tgt  = (bus.cur_x == tx_q) && (bus.cur_y == ty_q);

`ifdef MOVE_DIAGONAL_EN
  assign y_ok = 1'b1;
`else
  assign y_ok = (bus.cur_x == tx_q);
`endif

  assign auto_dir  = {y_ok & (bus.cur_y > ty_q), y_ok & (bus.cur_y < ty_q),
                      bus.cur_x > tx_q, bus.cur_x < tx_q};
  // An IDLE tick with a pending go is evaluated exactly like an AUTO tick.
  assign auto_eval = tick && !manual &&
                     (state_q == MODE_AUTO || (state_q == MODE_IDLE && go_pend_q));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= MODE_IDLE;
      cnt_q     <= '0;
      go_pend_q <= 1'b0;
      tx_q      <= '0;
      ty_q      <= '0;
      move_en_q <= 1'b0;
      dir_q     <= '0;
      arrived_q <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      go_pend_q <= go_pend_d;
      tx_q      <= tx_d;
      ty_q      <= ty_d;
      move_en_q <= move_en_d;
      dir_q     <= dir_d;
      arrived_q <= arrived_d;
      aborted_q <= aborted_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    go_pend_d = go_pend_q | bus.go;
    tx_d      = bus.go ? sat_x(bus.tgt_x) : tx_q;
    ty_d      = bus.go ? sat_y(bus.tgt_y) : ty_q;
    if (tick) begin
      case (state_q)
        MODE_IDLE: begin
          if (manual)         state_d = MODE_MANUAL;
          else if (go_pend_q) state_d = at_tgt ? MODE_IDLE : MODE_AUTO;
        end
        MODE_MANUAL: begin
          if (!manual) begin
            if (HOLD_FRAMES == 0) begin
              state_d = MODE_IDLE;
            end else begin
              state_d = MODE_HOLD;
              cnt_d   = HOLD_LOAD;
            end
          end
        end
        MODE_HOLD: begin
          if (manual) begin
            state_d = MODE_MANUAL;
          end else if (cnt_q <= CNT_ONE) begin
            state_d = MODE_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d   = cnt_q - CNT_ONE;
          end
        end
        MODE_AUTO: begin
          if (manual)      state_d = MODE_MANUAL;
          else if (at_tgt) state_d = MODE_IDLE;
        end
        default: state_d = MODE_IDLE;
      endcase
      // Pending go is consumed by IDLE/AUTO; an abort discards it even if go coincides.
      if (state_q == MODE_AUTO || (state_q == MODE_IDLE && !manual))
        go_pend_d = bus.go && !manual;
    end
  end

  always_comb begin
    move_en_d = move_en_q;
    dir_d     = dir_q;
    arrived_d = 1'b0;
    aborted_d = 1'b0;
    if (tick) begin
      move_en_d = 1'b0;
      dir_d     = '0;
      if (state_d == MODE_MANUAL) begin
        move_en_d = 1'b1;
        dir_d     = man_dir;
      end else if (state_d == MODE_AUTO) begin
        move_en_d = 1'b1;
        dir_d     = auto_dir;
      end
      arrived_d = auto_eval && at_tgt;
      aborted_d = (state_q == MODE_AUTO) && manual;
    end
  end

  assign bus.mode    = state_q;
  assign bus.busy    = (state_q == MODE_AUTO);
  assign bus.move_en = move_en_q;
  assign bus.up      = dir_q[3];
  assign bus.down    = dir_q[2];
  assign bus.left    = dir_q[1];
  assign bus.right   = dir_q[0];
  assign bus.arrived = arrived_q;
  assign bus.aborted = aborted_q;

endmodule
